alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, operand/result width.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit in cycles, legal range 2..255.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  host command present.
- cmd_ready  out  1  sequencer accepts command.
- cmd_op  in  2  opcode: 00 ADD, 01 SUB, 10 PAR, 11 COMP.
- cmd_a  in  DATA_WIDTH  operand A.
- cmd_b  in  DATA_WIDTH  operand B.
- rsp_valid  out  1  response held for host.
- rsp_ready  in  1  host consumes response.
- rsp_result  out  DATA_WIDTH  captured ALU result.
- rsp_overflow  out  1  captured overflow/borrow.
- rsp_timeout  out  1  watchdog expired for this command.
- alu_data  out  DATA_WIDTH  operand bus to ALU datapath.
- opcode_value  out  2  opcode to ALU datapath.
- store_a  out  1  load operand A into datapath.
- store_b  out  1  load operand B into datapath.
- start  out  1  launch datapath operation.
- alu_done  in  1  datapath result valid.
- result  in  DATA_WIDTH  datapath result.
- overflow  in  1  datapath overflow/borrow.
- busy  out  1  high in any state except IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, START, WAIT, RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE; handshake = cmd_valid & cmd_ready on posedge; IDLE->LOAD_A and cmd_a/cmd_b/cmd_op registered internally.
REQ-006 Handshake at edge N: LOAD_A during cycle N+1 (store_a=1, alu_data=A); LOAD_B during N+2 (store_b=1, alu_data=B); START during N+3.
REQ-007 start SHALL be 1 in START and WAIT; START->WAIT unconditionally unless alu_done=1.
REQ-008 alu_done=1 sampled in START or WAIT SHALL capture result into rsp_result, go RESP, drop start next cycle; earliest rsp_valid = cycle N+4.
REQ-009 rsp_overflow SHALL capture overflow for ADD/SUB and SHALL be 0 for PAR/COMP.
REQ-010 opcode_value SHALL equal the registered cmd_op from LOAD_A through WAIT and be 00 otherwise.
REQ-011 alu_data SHALL be 0 outside LOAD_A/LOAD_B.
REQ-012 store_a, store_b, start SHALL be mutually exclusive every cycle.
REQ-013 rsp_valid SHALL be 1 only in RESP, with rsp_result/rsp_overflow/rsp_timeout stable until rsp_valid & rsp_ready, then RESP->IDLE.
REQ-014 alu_done outside START/WAIT and rsp_ready outside RESP SHALL be ignored; cmd_valid outside IDLE SHALL not be accepted.
REQ-015 Back-to-back: cmd_ready SHALL reassert the cycle after the response handshake.

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE and all outputs to 0 except cmd_ready=1 while rst_n=1 follows; mid-operation reset SHALL discard the command without a response.
REQ-017 After rst_n deassertion the first command SHALL behave as REQ-006.

Configuration
REQ-018 Macro ALU_SEQ_TIMEOUT_EN defined: a counter SHALL count cycles in START+WAIT; on reaching TIMEOUT_CYCLES with no alu_done, go RESP with rsp_timeout=1, rsp_result=0, rsp_overflow=0, start dropped.
REQ-019 Macro undefined: no counter; WAIT SHALL persist until alu_done; rsp_timeout tied 0.

Verification
REQ-020 ADD A=8'h7F B=8'h01, alu_done 1 cycle after START -> pulses store_a/store_b/start in order, rsp_result=8'h80, rsp_overflow per datapath, rsp_valid at N+4.
REQ-021 PAR A=8'h0F B=8'hF0 with datapath overflow=1 -> rsp_overflow=0, opcode_value=10 held through WAIT.
REQ-022 rsp_ready held low 10 cycles -> rsp_* stable, cmd_ready=0, second cmd_valid not accepted until response handshake.
REQ-023 rst_n pulsed low during WAIT -> all outputs 0 asynchronously, no rsp_valid; next SUB 8'h05-8'h07 completes with rsp_result=8'hFE.
REQ-024 ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, alu_done never asserted -> rsp_timeout=1, rsp_result=0 after 16 start cycles; without macro start stays high.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a multi-cycle ALU datapath: accepts a host command, streams operands,
// launches the operation and holds the response. Optional watchdog enabled by ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout,
  output logic [DATA_WIDTH-1:0] alu_data,
  output logic [1:0]            opcode_value,
  output logic                  store_a,
  output logic                  store_b,
  output logic                  start,
  input  logic                  alu_done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..255");
  end

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ovf_q, ovf_d;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]            cnt_q, cnt_d;
  logic                  tmo_q, tmo_d;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    ovf_d        = ovf_q;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    store_a      = 1'b0;
    store_b      = 1'b0;
    start        = 1'b0;
    alu_data     = '0;
    opcode_value = 2'b00;
    rsp_timeout  = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
    cnt_d        = 8'd0;
    tmo_d        = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // Reset held low keeps the handshake closed even though the state is IDLE.
        cmd_ready = rst_n;
        if (cmd_valid && rst_n) begin
          state_d = S_LOAD_A;
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
        end
      end
      S_LOAD_A: begin
        store_a      = 1'b1;
        alu_data     = a_q;
        opcode_value = op_q;
        state_d      = S_LOAD_B;
      end
      S_LOAD_B: begin
        store_b      = 1'b1;
        alu_data     = b_q;
        opcode_value = op_q;
        state_d      = S_START;
      end
      S_START, S_WAIT: begin
        start        = 1'b1;
        opcode_value = op_q;
        state_d      = S_WAIT;
        if (alu_done) begin
          state_d = S_RESP;
          res_d   = result;
          // Only ADD/SUB (op[1]==0) produce a meaningful carry/borrow.
          ovf_d   = overflow & ~op_q[1];
`ifdef ALU_SEQ_TIMEOUT_EN
          tmo_d   = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_RESP;
          res_d   = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy         = (state_q != S_IDLE);
    rsp_result   = (state_q == S_RESP) ? res_q : '0;
    rsp_overflow = (state_q == S_RESP) & ovf_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    rsp_timeout  = (state_q == S_RESP) & tmo_q;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed, table-driven bench for alu_cmd_sequencer; the bench plays host and ALU datapath.
// Timeout expectations follow ALU_SEQ_TIMEOUT_EN.
module tb_alu_cmd_sequencer;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_a, cmd_b;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_overflow, rsp_timeout;
  logic [DW-1:0] alu_data;
  logic [1:0]    opcode_value;
  logic          store_a, store_b, start;
  logic          alu_done;
  logic [DW-1:0] result;
  logic          overflow;
  logic          busy;

  alu_cmd_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
    .alu_data(alu_data), .opcode_value(opcode_value),
    .store_a(store_a), .store_b(store_b), .start(start),
    .alu_done(alu_done), .result(result), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         done_dly;  // cycles after entering START before alu_done
    int         rdy_dly;   // cycles rsp_ready is held low in RESP
    logic [7:0] exp_res;
    logic       exp_ovf;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Datapath stand-in: ADD carry, SUB borrow, PAR = parity of {a,b}, COMP = ~a.
  // PAR/COMP deliberately raise overflow so masking can be observed.
  function automatic logic [8:0] dp(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   dp = {1'b0, a} + {1'b0, b};
      2'b01:   dp = {(a < b), 8'(a - b)};
      2'b10:   dp = {1'b1, 7'b0, ^{a, b}};
      default: dp = {1'b1, ~a};
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 0);
    check({tag, "_rsp_ovf"}, 32'(rsp_overflow), 0);
    check({tag, "_rsp_tmo"}, 32'(rsp_timeout), 0);
    check({tag, "_alu_data"}, 32'(alu_data), 0);
    check({tag, "_opcode"}, 32'(opcode_value), 0);
    check({tag, "_strobes"}, 32'({store_a, store_b, start}), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Full command from handshake to response handshake. keep_valid leaves a second
  // command pending during RESP to show it is not accepted early.
  task automatic do_cmd(input vec_t v, input bit keep_valid);
    logic [7:0] la, lb;
    logic [8:0] r;
    check("idle_ready", 32'(cmd_ready), 1);
    check("idle_busy", 32'(busy), 0);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
    step();                               // edge N
    cmd_valid = 1'b0; cmd_a = 8'h5A; cmd_b = 8'hA5; cmd_op = ~v.op;
    alu_done = 1'b1; rsp_ready = 1'b1;    // must be ignored outside START/WAIT/RESP
    check("loada_strobes", 32'({store_a, store_b, start}), 32'b100);
    check("loada_data", 32'(alu_data), 32'(v.a));
    check("loada_op", 32'(opcode_value), 32'(v.op));
    check("loada_ready", 32'(cmd_ready), 0);
    la = alu_data;
    step();                               // N+2
    check("loadb_strobes", 32'({store_a, store_b, start}), 32'b010);
    check("loadb_data", 32'(alu_data), 32'(v.b));
    check("loadb_op", 32'(opcode_value), 32'(v.op));
    lb = alu_data;
    r = dp(v.op, la, lb);
    alu_done = 1'b0; rsp_ready = 1'b0;
    step();                               // N+3
    check("start_strobes", 32'({store_a, store_b, start}), 32'b001);
    check("start_data", 32'(alu_data), 0);
    check("start_op", 32'(opcode_value), 32'(v.op));
    check("start_rsp", 32'(rsp_valid), 0);
    for (int k = 0; k <= v.done_dly; k++) begin
      if (k == v.done_dly) begin
        alu_done = 1'b1; result = r[7:0]; overflow = r[8];
      end else begin
        result = 8'hC3; overflow = 1'b1;
      end
      step();
      if (k < v.done_dly) begin
        check("wait_start", 32'(start), 1);
        check("wait_op", 32'(opcode_value), 32'(v.op));
        check("wait_rsp", 32'(rsp_valid), 0);
      end
    end
    alu_done = 1'b0; result = 8'h00; overflow = 1'b0;
    check("resp_valid", 32'(rsp_valid), 1);
    check("resp_strobes", 32'({store_a, store_b, start}), 0);
    check("resp_result", 32'(rsp_result), 32'(v.exp_res));
    check("resp_ovf", 32'(rsp_overflow), 32'(v.exp_ovf));
    check("resp_tmo", 32'(rsp_timeout), 0);
    check("resp_op", 32'(opcode_value), 0);
    if (keep_valid) begin
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'hAA; cmd_b = 8'h55;
    end
    for (int k = 0; k < v.rdy_dly; k++) begin
      step();
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_result", 32'(rsp_result), 32'(v.exp_res));
      check("hold_ovf", 32'(rsp_overflow), 32'(v.exp_ovf));
      check("hold_ready", 32'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("post_valid", 32'(rsp_valid), 0);
    check("post_ready", 32'(cmd_ready), 1);
  endtask

  vec_t vecs[8];
  int   n_start;

  initial begin
    vecs[0] = '{op: 2'b00, a: 8'h7F, b: 8'h01, done_dly: 0, rdy_dly: 0, exp_res: 8'h80, exp_ovf: 1'b0};
    vecs[1] = '{op: 2'b00, a: 8'hFF, b: 8'h01, done_dly: 1, rdy_dly: 2, exp_res: 8'h00, exp_ovf: 1'b1};
    vecs[2] = '{op: 2'b01, a: 8'h05, b: 8'h07, done_dly: 2, rdy_dly: 0, exp_res: 8'hFE, exp_ovf: 1'b1};
    vecs[3] = '{op: 2'b01, a: 8'h07, b: 8'h05, done_dly: 0, rdy_dly: 1, exp_res: 8'h02, exp_ovf: 1'b0};
    vecs[4] = '{op: 2'b10, a: 8'h0F, b: 8'hF0, done_dly: 1, rdy_dly: 0, exp_res: 8'h00, exp_ovf: 1'b0};
    vecs[5] = '{op: 2'b10, a: 8'h01, b: 8'h00, done_dly: 0, rdy_dly: 0, exp_res: 8'h01, exp_ovf: 1'b0};
    vecs[6] = '{op: 2'b11, a: 8'h3C, b: 8'h00, done_dly: 3, rdy_dly: 1, exp_res: 8'hC3, exp_ovf: 1'b0};
    vecs[7] = '{op: 2'b00, a: 8'h80, b: 8'h80, done_dly: 0, rdy_dly: 0, exp_res: 8'h00, exp_ovf: 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; alu_done = 1'b0; result = '0; overflow = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(cmd_ready), 1);
    step();

    foreach (vecs[i]) do_cmd(vecs[i], 1'b0);

    // Response held 10 cycles with a second command waiting; it enters only after the handshake.
    do_cmd('{op: 2'b01, a: 8'h34, b: 8'h12, done_dly: 1, rdy_dly: 10, exp_res: 8'h22, exp_ovf: 1'b0}, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("b2b_store_a", 32'(store_a), 1);
    check("b2b_data_a", 32'(alu_data), 32'h AA);
    step();
    check("b2b_data_b", 32'(alu_data), 32'h55);
    step();
    check("b2b_start", 32'(start), 1);
    alu_done = 1'b1; result = 8'hFF; overflow = 1'b0;
    step();
    alu_done = 1'b0;
    check("b2b_result", 32'(rsp_result), 32'hFF);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("b2b_idle", 32'(cmd_ready), 1);

    // Reset during WAIT: outputs drop at once, command discarded.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h11; cmd_b = 8'h22;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    check("pre_rst_wait", 32'(start), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
    check("after_rst_rsp", 32'(rsp_valid), 0);
    check("after_rst_busy", 32'(busy), 0);
    do_cmd('{op: 2'b01, a: 8'h05, b: 8'h07, done_dly: 0, rdy_dly: 0, exp_res: 8'hFE, exp_ovf: 1'b1}, 1'b0);

    // alu_done never arrives.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h01; cmd_b = 8'h02;
    step();
    cmd_valid = 1'b0;
    step(); step();
    result = 8'h55; overflow = 1'b1;
    n_start = 0;
`ifdef ALU_SEQ_TIMEOUT_EN
    for (int k = 0; k < 100 && !rsp_valid; k++) begin
      if (start) n_start++;
      step();
    end
    check("tmo_start_cycles", 32'(n_start), 32'(TO));
    check("tmo_valid", 32'(rsp_valid), 1);
    check("tmo_flag", 32'(rsp_timeout), 1);
    check("tmo_result", 32'(rsp_result), 0);
    check("tmo_ovf", 32'(rsp_overflow), 0);
    check("tmo_start_drop", 32'(start), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("tmo_idle", 32'(cmd_ready), 1);
`else
    for (int k = 0; k < 40; k++) begin
      if (start && !rsp_valid) n_start++;
      step();
    end
    check("notmo_start_cycles", 32'(n_start), 40);
    check("notmo_rsp", 32'(rsp_valid), 0);
    check("notmo_flag", 32'(rsp_timeout), 0);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("notmo_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("notmo_recover", 32'(cmd_ready), 1);
`endif
    result = '0; overflow = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
